// File: rtl/mby_msh_col_wr_req_gen_if.sv
// Shared request/data types and the client-side request handshake bundle for
// the mesh column write requestor.
//   msh_col_wr_req_t : column write request (vld qualifies it on the mesh nets)
//   msh_dbus_t       : write data beat
// Interface signals (client -> stage): i_req_vld, i_req_plane, i_req, i_dbus
//                   (stage -> client): o_req_rdy
package mby_msh_col_wr_req_gen_pkg;
   typedef struct packed {
      logic        vld;
      logic [3:0]  id;
      logic [15:0] addr;
   } msh_col_wr_req_t;

   typedef struct packed {
      logic [31:0] data;
   } msh_dbus_t;
endpackage

interface mby_msh_col_wr_req_gen_if
   import mby_msh_col_wr_req_gen_pkg::*;
#(
   parameter int NUM_PLANES = 2,
   parameter int PL_W       = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1
);
   logic            i_req_vld;
   logic            o_req_rdy;
   logic [PL_W-1:0] i_req_plane;
   msh_col_wr_req_t i_req;
   msh_dbus_t       i_dbus;

   modport master (output i_req_vld, i_req_plane, i_req, i_dbus, input o_req_rdy);
   modport slave  (input i_req_vld, i_req_plane, i_req, i_dbus, output o_req_rdy);
endinterface

// File: rtl/mby_msh_col_wr_req_gen.sv
// Requestor-side source stage for a mesh column write port.
// A one-entry holding stage accepts client requests (req_if, valid/ready) and
// issues each onto the selected plane's registered column write nets when that
// plane has credit. Per-plane credit counters are replenished by the
// responder's credit-return pulses.
// Ports:
//   cclk, rst_n            : clock, async active-low reset
//   req_if (slave)         : client request handshake, plane select, req, data
//   o_wr_req / o_wr_dbus   : per-plane registered write request/data, vld one cycle per issue
//   i_crdt_rtn_for_wr_req  : per-plane credit return, one credit per high cycle
//   o_crdt_avail           : per-plane current credit count
//   o_err                  : sticky errors, [0] credit overflow, [1] illegal plane
module mby_msh_col_wr_req_gen
   import mby_msh_col_wr_req_gen_pkg::*;
#(
   parameter int NUM_MSH_PLANES = 2,
   parameter int NUM_PLANES     = NUM_MSH_PLANES,
   parameter int CRDT_INIT      = 8,
   parameter int CRDT_W         = $clog2(CRDT_INIT + 1),
   parameter int PL_W           = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1
) (
   input  logic                              cclk,
   input  logic                              rst_n,
   mby_msh_col_wr_req_gen_if.slave           req_if,
   output msh_col_wr_req_t [NUM_PLANES-1:0]  o_wr_req,
   output msh_dbus_t       [NUM_PLANES-1:0]  o_wr_dbus,
   input  logic            [NUM_PLANES-1:0]  i_crdt_rtn_for_wr_req,
   output logic [NUM_PLANES-1:0][CRDT_W-1:0] o_crdt_avail,
   output logic            [1:0]             o_err
);

   logic            held;
   msh_col_wr_req_t h_req;
   msh_dbus_t       h_dbus;
   logic [PL_W-1:0] h_plane;

   logic [CRDT_W-1:0]     crdt [NUM_PLANES];
   logic [NUM_PLANES-1:0] ovf;

   logic            plane_ok, has_crdt, issue, drop, accept;
   msh_col_wr_req_t wr_req_q;

   // Plane compare is done one bit wider so a power-of-2 NUM_PLANES is not truncated.
   assign plane_ok = ({1'b0, h_plane} < (PL_W+1)'(NUM_PLANES));

   always_comb begin
      has_crdt = 1'b0;
      if (plane_ok) has_crdt = (crdt[h_plane] != '0);
   end

   assign issue          = held && has_crdt;
   assign drop           = held && !plane_ok;
   assign req_if.o_req_rdy = !held || issue;
   assign accept         = req_if.i_req_vld && req_if.o_req_rdy;

   // The client's vld field is meaningless here; the issued copy is always marked valid.
   always_comb begin
      wr_req_q     = h_req;
      wr_req_q.vld = 1'b1;
   end

   // Holding stage: a same-edge accept refills the slot being drained.
   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) begin
         held    <= 1'b0;
         h_req   <= '0;
         h_dbus  <= '0;
         h_plane <= '0;
      end else if (accept) begin
         held    <= 1'b1;
         h_req   <= req_if.i_req;
         h_dbus  <= req_if.i_dbus;
         h_plane <= req_if.i_req_plane;
      end else if (issue || drop) begin
         held    <= 1'b0;
      end
   end

   // Output nets are pulsed: cleared every cycle, written only on an issue edge.
   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) begin
         o_wr_req  <= '0;
         o_wr_dbus <= '0;
      end else begin
         o_wr_req  <= '0;
         o_wr_dbus <= '0;
         if (issue) begin
            o_wr_req[h_plane]  <= wr_req_q;
            o_wr_dbus[h_plane] <= h_dbus;
         end
      end
   end

   for (genvar p = 0; p < NUM_PLANES; p++) begin : g_plane
      logic dec, inc;
      assign dec = issue && (h_plane == PL_W'(p));
      assign inc = i_crdt_rtn_for_wr_req[p];
      // Return into a full counter with no issue is an overflow; count saturates.
      assign ovf[p] = inc && !dec && (crdt[p] == CRDT_W'(CRDT_INIT));

      always_ff @(posedge cclk or negedge rst_n) begin
         if (!rst_n)             crdt[p] <= CRDT_W'(CRDT_INIT);
         else if (inc && !dec && !ovf[p]) crdt[p] <= crdt[p] + 1'b1;
         else if (dec && !inc)   crdt[p] <= crdt[p] - 1'b1;
      end

      assign o_crdt_avail[p] = crdt[p];
   end

   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) o_err <= '0;
      else        o_err <= o_err | {drop, |ovf};
   end

endmodule

// File: tb/tb_mby_msh_col_wr_req_gen.sv
module tb_mby_msh_col_wr_req_gen;
   import mby_msh_col_wr_req_gen_pkg::*;

   logic cclk = 1'b0;
   logic rst_n;
   always #5 cclk = ~cclk;

   mby_msh_col_wr_req_gen_if #(.NUM_PLANES(2)) rif ();
   msh_col_wr_req_t [1:0]      o_wr_req;
   msh_dbus_t       [1:0]      o_wr_dbus;
   logic            [1:0]      crdt_rtn;
   logic            [1:0][3:0] crdt_av;
   logic            [1:0]      err;

   mby_msh_col_wr_req_gen #(.NUM_MSH_PLANES(2), .CRDT_INIT(8)) dut (
      .cclk                  (cclk),
      .rst_n                 (rst_n),
      .req_if                (rif.slave),
      .o_wr_req              (o_wr_req),
      .o_wr_dbus             (o_wr_dbus),
      .i_crdt_rtn_for_wr_req (crdt_rtn),
      .o_crdt_avail          (crdt_av),
      .o_err                 (err)
   );

   int checks = 0;
   int errors = 0;
   logic [32:0] sbq[$];   // {plane, data} in acceptance order

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive inputs, sample ready before the edge, then check any issue against the scoreboard.
   task automatic step(input logic v, input logic pl, input logic [31:0] d, input logic [1:0] rtn,
                       output logic rdy_s, output int iss);
      logic [32:0] e;
      rif.i_req_vld   = v;
      rif.i_req_plane = pl;
      rif.i_req       = '{vld: v, id: d[3:0], addr: d[15:0]};
      rif.i_dbus      = '{data: d};
      crdt_rtn        = rtn;
      #1 rdy_s = rif.o_req_rdy;
      @(posedge cclk); #1;
      if (v && rdy_s) sbq.push_back({pl, d});
      iss = 0;
      for (int p = 0; p < 2; p++) begin
         if (o_wr_req[p].vld) begin
            iss++;
            chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
               e = sbq.pop_front();
               chk("sb_plane", 32'(p), 32'(e[32]));
               chk("sb_data", o_wr_dbus[p].data, e[31:0]);
               chk("sb_addr", 32'(o_wr_req[p].addr), 32'(e[15:0]));
               chk("sb_id", 32'(o_wr_req[p].id), 32'(e[3:0]));
            end
         end
      end
      chk("single_issue", 32'(iss <= 1), 32'd1);
   endtask

   typedef struct {
      logic        v;
      logic        pl;
      logic [31:0] d;
      logic [1:0]  rtn;
      logic        erdy;
      logic [1:0]  ev;
      logic [31:0] edata;
      int          c0;
      int          c1;
      logic [1:0]  eerr;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic rdy_s;
      int   iss, sent, n_iss, first, last, cyc;

      //         v  pl d      rtn    rdy ev     edata  c0 c1 err
      tbl[0]  = '{1, 1, 32'hA1, 2'b00, 1, 2'b00, 32'h0,  8, 8, 2'b00};
      tbl[1]  = '{0, 0, 32'h0,  2'b00, 1, 2'b10, 32'hA1, 8, 7, 2'b00};
      tbl[2]  = '{0, 0, 32'h0,  2'b00, 1, 2'b00, 32'h0,  8, 7, 2'b00};
      tbl[3]  = '{1, 0, 32'hB0, 2'b00, 1, 2'b00, 32'h0,  8, 7, 2'b00};
      tbl[4]  = '{1, 0, 32'hB1, 2'b00, 1, 2'b01, 32'hB0, 7, 7, 2'b00};
      tbl[5]  = '{1, 0, 32'hB2, 2'b00, 1, 2'b01, 32'hB1, 6, 7, 2'b00};
      tbl[6]  = '{1, 0, 32'hB3, 2'b00, 1, 2'b01, 32'hB2, 5, 7, 2'b00};
      tbl[7]  = '{0, 0, 32'h0,  2'b01, 1, 2'b01, 32'hB3, 5, 7, 2'b00};
      tbl[8]  = '{0, 0, 32'h0,  2'b10, 1, 2'b00, 32'h0,  5, 8, 2'b00};
      tbl[9]  = '{0, 0, 32'h0,  2'b10, 1, 2'b00, 32'h0,  5, 8, 2'b01};
      tbl[10] = '{0, 0, 32'h0,  2'b01, 1, 2'b00, 32'h0,  6, 8, 2'b01};
      tbl[11] = '{0, 0, 32'h0,  2'b11, 1, 2'b00, 32'h0,  7, 8, 2'b01};

      rst_n = 1'b0;
      rif.i_req_vld = 1'b0; rif.i_req_plane = 1'b0; rif.i_req = '0; rif.i_dbus = '0;
      crdt_rtn = 2'b00;
      repeat (2) @(posedge cclk);
      #1;
      chk("rst_rdy",   32'(rif.o_req_rdy), 32'd1);
      chk("rst_req",   32'(o_wr_req),  32'd0);
      chk("rst_dbus0", o_wr_dbus[0].data, 32'd0);
      chk("rst_dbus1", o_wr_dbus[1].data, 32'd0);
      chk("rst_crdt0", 32'(crdt_av[0]), 32'd8);
      chk("rst_crdt1", 32'(crdt_av[1]), 32'd8);
      chk("rst_err",   32'(err), 32'd0);
      rst_n = 1'b1;

      // Table: single plane-1 request, plane-0 burst to count 5, issue+return, overflow.
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].v, tbl[i].pl, tbl[i].d, tbl[i].rtn, rdy_s, iss);
         chk($sformatf("t%0d_rdy", i), 32'(rdy_s), 32'(tbl[i].erdy));
         chk($sformatf("t%0d_vld", i), 32'({o_wr_req[1].vld, o_wr_req[0].vld}), 32'(tbl[i].ev));
         chk($sformatf("t%0d_db0", i), o_wr_dbus[0].data, tbl[i].ev[0] ? tbl[i].edata : 32'h0);
         chk($sformatf("t%0d_db1", i), o_wr_dbus[1].data, tbl[i].ev[1] ? tbl[i].edata : 32'h0);
         chk($sformatf("t%0d_c0", i), 32'(crdt_av[0]), 32'(tbl[i].c0));
         chk($sformatf("t%0d_c1", i), 32'(crdt_av[1]), 32'(tbl[i].c1));
         chk($sformatf("t%0d_err", i), 32'(err), 32'(tbl[i].eerr));
      end
      step(0, 0, 0, 2'b00, rdy_s, iss);
      chk("err_sticky", 32'(err), 32'd1);

      // Synchronous-looking reset pulse between scenarios also clears the sticky error.
      rst_n = 1'b0; sbq.delete();
      #3;
      chk("err_cleared", 32'(err), 32'd0);
      rst_n = 1'b1;

      // 10 back-to-back to plane 0 with no returns: 8 issue consecutively.
      sent = 0; n_iss = 0; first = -1; last = -1; cyc = 0;
      while (n_iss < 8 && cyc < 40) begin
         step(sent < 10, 0, 32'h100 + 32'(sent), 2'b00, rdy_s, iss);
         if (sent < 10 && rdy_s) sent++;
         if (iss != 0) begin
            if (first < 0) first = cyc;
            last = cyc;
         end
         n_iss += iss;
         cyc++;
      end
      chk("burst_issued", 32'(n_iss), 32'd8);
      chk("burst_consecutive", 32'(last - first), 32'd7);
      step(1, 0, 32'h100 + 32'(sent), 2'b00, rdy_s, iss);
      chk("stall_iss", 32'(iss), 32'd0);
      chk("stall_rdy", 32'(rif.o_req_rdy), 32'd0);
      chk("stall_crdt0", 32'(crdt_av[0]), 32'd0);
      // Return at edge R must not issue at R (no bypass).
      step(1, 0, 32'h100 + 32'(sent), 2'b01, rdy_s, iss);
      chk("rtn_no_bypass", 32'(iss), 32'd0);
      chk("rtn_crdt0", 32'(crdt_av[0]), 32'd1);
      step(1, 0, 32'h100 + 32'(sent), 2'b00, rdy_s, iss);
      if (rdy_s) sent++;
      chk("rtn_next_issue", 32'(iss), 32'd1);
      chk("rtn_next_crdt0", 32'(crdt_av[0]), 32'd0);
      chk("rtn_next_sent", 32'(sent), 32'd10);

      // Starved plane 0 with a return every cycle: streams at one per cycle, in order.
      n_iss = 0; first = -1; last = -1; cyc = 0;
      while ((sent < 16 || sbq.size() != 0) && cyc < 40) begin
         step(sent < 16, 0, 32'h100 + 32'(sent), 2'b01, rdy_s, iss);
         if (sent < 16 && rdy_s) sent++;
         if (iss != 0) begin
            if (first < 0) first = cyc;
            last = cyc;
         end
         n_iss += iss;
         cyc++;
      end
      chk("stream_issued", 32'(n_iss), 32'd7);
      chk("stream_consecutive", 32'(last - first), 32'd6);
      chk("stream_first", 32'(first), 32'd1);
      chk("stream_crdt0", 32'(crdt_av[0]), 32'd1);

      // Async reset while an entry is held with zero credit and an issue is on the nets.
      step(1, 0, 32'h200, 2'b00, rdy_s, iss);
      step(1, 0, 32'h201, 2'b00, rdy_s, iss);
      chk("pre_rst_vld", 32'(o_wr_req[0].vld), 32'd1);
      chk("pre_rst_crdt0", 32'(crdt_av[0]), 32'd0);
      chk("pre_rst_rdy", 32'(rif.o_req_rdy), 32'd0);
      #2 rst_n = 1'b0;
      rif.i_req_vld = 1'b0;
      #1;
      chk("arst_req", 32'(o_wr_req), 32'd0);
      chk("arst_dbus0", o_wr_dbus[0].data, 32'd0);
      chk("arst_crdt0", 32'(crdt_av[0]), 32'd8);
      chk("arst_crdt1", 32'(crdt_av[1]), 32'd8);
      chk("arst_rdy", 32'(rif.o_req_rdy), 32'd1);
      sbq.delete();
      @(posedge cclk); #4 rst_n = 1'b1;
      n_iss = 0;
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 2'b00, rdy_s, iss);
         n_iss += iss;
      end
      chk("post_rst_no_issue", 32'(n_iss), 32'd0);
      chk("post_rst_crdt0", 32'(crdt_av[0]), 32'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
